// File: rtl/inport_fifo.sv
// Input-port FIFO: buffers words from an external device and presents the
// head word to the datapath input port. The control unit pops at most once
// per rising edge of rd_en, however long rd_en is held.
// Optional feature: define INPORT_FIFO_OVF_EN to build the sticky overflow
// flag (set by dev_valid while full, cleared by ovf_clr or reset).
module inport_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dev_valid,
  input  logic [31:0]   dev_data,
  output logic          dev_ready,
  input  logic          rd_en,
  output logic [31:0]   inPort_input,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  // Storage is never reset; outputs only read entries between rd_ptr and wr_ptr.
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_en_q;
  logic          pop_edge;
  logic          push;
  logic          pop;

  // Flags come only from the registered count, so no input-to-flag path.
  assign empty     = (count_q == '0);
  assign full      = (count_q == FullCount);
  assign dev_ready = ~full;
  assign count     = count_q;

  // Pop requests are edge-detected so a held rd_en pops exactly once; an edge
  // seen while empty is simply dropped.
  assign pop_edge = rd_en & ~rd_en_q;
  assign push     = dev_valid & dev_ready;
  assign pop      = pop_edge & ~empty;

  // Head word, forced to zero when there is nothing valid to show.
  assign inPort_input = empty ? 32'h0 : mem[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_en_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_en_q  <= rd_en;
    end
  end

  // Data array write; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= dev_data;
  end

`ifdef INPORT_FIFO_OVF_EN
  logic ovf_q;

  // Sticky overflow: a new offending push wins over a clear on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (dev_valid && full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule
